// File: rtl/inv_kaliski_multi.sv
// inv_kaliski_multi: Kaliski modular inverter (almost-inverse + domain conversion); INV_CONST_TIME_EN selects fixed latency
module inv_kaliski_multi #(
  parameter int WIDTH = 256,
  parameter int KW = $clog2(2*WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_inv,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             done_inv,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [KW-1:0]    k_out
);
  typedef enum logic [2:0] {IDLE, CHK, PH1, CORR, PH2, DONE, ERR} state_t;
  state_t state;
  logic [WIDTH-1:0] u, v, p, x, u_n, v_n, x_c, x_n;
  logic [WIDTH+1:0] r, s, r_n, s_n, r_c;
  logic [WIDTH:0] x_sum, x_t;
  logic [KW-1:0] k, h, h_c;
  logic [1:0] md;
  logic dbl, dbl_c, ue, ve, gt;
`ifdef INV_CONST_TIME_EN
  logic [KW-1:0] cyc;
  logic last;
  assign last = cyc == KW'(2*WIDTH-1);
`endif
  // next-iteration values, correction step and phase-2 step, all single-cycle full width
  always_comb begin
    ue = !u[0];
    ve = !v[0];
    gt = u > v;
    u_n = ue ? u >> 1 : (!ve && gt) ? (u - v) >> 1 : u;
    v_n = ue ? v : ve ? v >> 1 : gt ? v : (v - u) >> 1;
    r_n = ue ? r : (ve || !gt) ? r << 1 : r + s;
    s_n = (ue || (!ve && gt)) ? s << 1 : ve ? s : s + r;
    r_c = (r >= {2'b0, p}) ? r - {2'b0, p} : r;
    x_c = WIDTH'({2'b0, p} - r_c);
    dbl_c = md == 2'd2 && k < KW'(WIDTH);
    h_c = md == 2'd1 ? k : md != 2'd2 ? '0 : dbl_c ? KW'(WIDTH) - k : k - KW'(WIDTH);
    x_sum = {1'b0, x} + (x[0] ? {1'b0, p} : '0);
    x_t = {x, 1'b0};
    x_n = dbl ? WIDTH'(x_t >= {1'b0, p} ? x_t - {1'b0, p} : x_t) : WIDTH'(x_sum >> 1);
  end
  // control FSM with registered outputs; busy stays high through the done cycle so a start there is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done_inv <= 1'b0;
      err <= 1'b0;
      result <= '0;
      k_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_inv <= 1'b0;
          busy <= 1'b0;
          if (start_inv && !busy) begin
            busy <= 1'b1;
            p <= P;
            u <= P;
            v <= a;
            md <= mode;
            r <= '0;
            s <= (WIDTH+2)'(1);
            k <= '0;
`ifdef INV_CONST_TIME_EN
            cyc <= '0;
`endif
            state <= CHK;
          end
        end
        CHK: state <= (!p[0] || p < WIDTH'(3) || v == '0 || v >= p || md == 2'd3) ? ERR : PH1;
        PH1: begin
`ifdef INV_CONST_TIME_EN
          if (v != '0) begin
            u <= u_n;
            v <= v_n;
            r <= r_n;
            s <= s_n;
            k <= k + KW'(1);
          end
          cyc <= last ? '0 : cyc + KW'(1);
          state <= last ? CORR : PH1;
`else
          u <= u_n;
          v <= v_n;
          r <= r_n;
          s <= s_n;
          k <= k + KW'(1);
          if (v_n == '0) state <= CORR;
`endif
        end
        CORR: begin
          if (u != WIDTH'(1)) state <= ERR;
          else begin
            x <= x_c;
            h <= h_c;
            dbl <= dbl_c;
`ifdef INV_CONST_TIME_EN
            state <= PH2;
`else
            state <= h_c == '0 ? DONE : PH2;
`endif
          end
        end
        PH2: begin
`ifdef INV_CONST_TIME_EN
          if (h != '0) begin
            x <= x_n;
            h <= h - KW'(1);
          end
          cyc <= last ? '0 : cyc + KW'(1);
          state <= last ? DONE : PH2;
`else
          x <= x_n;
          h <= h - KW'(1);
          if (h == KW'(1)) state <= DONE;
`endif
        end
        DONE: begin
          done_inv <= 1'b1;
          err <= 1'b0;
          result <= x;
          k_out <= k;
          state <= IDLE;
        end
        ERR: begin
          done_inv <= 1'b1;
          err <= 1'b1;
          result <= '0;
          k_out <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_kaliski_multi.sv
// tb_inv_kaliski_multi: table-driven and scoreboard-checked bench for inv_kaliski_multi at WIDTH=8
module tb_inv_kaliski_multi;
  localparam int W = 8;
  localparam int KW = $clog2(2*W+1);
  logic clk = 1'b0, reset = 1'b1, start_inv = 1'b0;
  logic [1:0] mode = '0;
  logic [W-1:0] a = '0, P = '0;
  logic busy, done_inv, err;
  logic [W-1:0] result;
  logic [KW-1:0] k_out;
  int checks = 0, errors = 0;
  typedef struct {int p; int a; int m; int e; int res; int k; int lat;} vec_t;
  vec_t sb[$];
  vec_t tbl[12];

  inv_kaliski_multi #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_inv(start_inv), .mode(mode), .a(a), .P(P),
    .busy(busy), .done_inv(done_inv), .err(err), .result(result), .k_out(k_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t model(input int p, input int av, input int m);
    vec_t e;
    int u, v, r, s, k, inv, x, h;
    e = '{p, av, m, 0, 0, 0, 2};
    if (p % 2 == 0 || p < 3 || av == 0 || av >= p || m == 3) begin
      e.e = 1;
      return e;
    end
    u = p; v = av; r = 0; s = 1; k = 0;
    while (v != 0) begin
      if (u % 2 == 0) begin u = u / 2; s = s * 2; end
      else if (v % 2 == 0) begin v = v / 2; r = r * 2; end
      else if (u > v) begin u = (u - v) / 2; r = r + s; s = s * 2; end
      else begin v = (v - u) / 2; s = s + r; r = r * 2; end
      k++;
    end
    if (u != 1) begin
      e.e = 1;
      e.lat = k + 3;
      return e;
    end
    inv = 0;
    for (int i = 1; i < p; i++) if ((av * i) % p == 1) inv = i;
    x = inv; h = 0;
    if (m == 0) for (int i = 0; i < k; i++) x = (2 * x) % p;
    else if (m == 1) h = k;
    else begin
      x = (inv * 256) % p;
      h = k >= W ? k - W : W - k;
    end
    e.res = x;
    e.k = k;
    e.lat = k + h + 3;
    return e;
  endfunction

  function automatic int lat_of(input vec_t e);
`ifdef INV_CONST_TIME_EN
    return e.e == 0 ? 4*W+3 : e.lat == 2 ? 2 : 2*W+3;
`else
    return e.lat;
`endif
  endfunction

  task automatic run_op(input vec_t e);
    int n;
    vec_t q;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    start_inv = 1'b1;
    P = W'(e.p);
    a = W'(e.a);
    mode = 2'(e.m);
    sb.push_back(e);
    @(negedge clk);
    start_inv = 1'b0;
    check("busy_after_accept", busy, 1);
    n = 0;
    while (!done_inv && n < 5000) begin @(negedge clk); n++; end
    q = sb.pop_front();
    if (!done_inv) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done_inv for P=%0d a=%0d mode=%0d", q.p, q.a, q.m);
      return;
    end
    check("err", err, q.e);
    check("result", result, q.res);
    check("k_out", k_out, q.k);
    check("latency", n, lat_of(q));
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_one_cycle", done_inv, 0);
  endtask

  initial begin
    int n, dones, p, av;
    tbl[0]  = '{7, 3, 0, 0, 3, 4, 7};
    tbl[1]  = '{7, 3, 1, 0, 5, 4, 11};
    tbl[2]  = '{7, 3, 2, 0, 6, 4, 11};
    tbl[3]  = '{8, 3, 0, 1, 0, 0, 2};
    tbl[4]  = '{7, 0, 1, 1, 0, 0, 2};
    tbl[5]  = '{7, 7, 1, 1, 0, 0, 2};
    tbl[6]  = '{7, 3, 3, 1, 0, 0, 2};
    tbl[7]  = '{1, 1, 0, 1, 0, 0, 2};
    tbl[8]  = '{9, 6, 1, 1, 0, 0, 6};
    tbl[9]  = '{3, 2, 1, 0, 2, 3, 9};
    tbl[10] = '{251, 1, 2, 0, 5, 8, 11};
    tbl[11] = '{251, 1, 1, 0, 1, 8, 19};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done_inv, 0);
    check("reset_err", err, 0);
    check("reset_result", result, 0);
    check("reset_k", k_out, 0);
    for (int i = 0; i < 12; i++) run_op(tbl[i]);
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(3, 255) | 1;
      av = $urandom_range(1, p - 1);
      run_op(model(p, av, $urandom_range(0, 2)));
    end
    // start held high across the whole operation and the done cycle
    while (busy) @(negedge clk);
    start_inv = 1'b1; P = 8'd7; a = 8'd3; mode = 2'd0;
    n = 0;
    @(negedge clk);
    while (!done_inv && n < 100) begin @(negedge clk); n++; end
    check("held_done_seen", done_inv, 1);
    check("held_latency", n, lat_of(tbl[0]));
    check("held_result", result, 3);
    check("held_busy_in_done", busy, 1);
    @(negedge clk);
    check("held_busy_after_done", busy, 0);
    start_inv = 1'b0;
    dones = 0;
    repeat (40) begin @(negedge clk); if (done_inv) dones++; end
    check("held_extra_done", dones, 0);
    // reset in the middle of phase 1
    start_inv = 1'b1; P = 8'd7; a = 8'd3; mode = 2'd1;
    @(negedge clk);
    start_inv = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done_inv, 0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done_inv) dones++; end
    check("abort_no_done", dones, 0);
    run_op(tbl[1]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
